// File: rtl/regfile_wb_scoreboard.sv
// Register-file writeback arbiter (LSU over buffered ALU) with a
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scoreboard #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic [4:0]       issue_rd,
    output logic             issue_stall,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [4:0]       lsu_rd,
    input  logic [31:0]      lsu_data,
    output logic             rf_we,
    output logic [4:0]       rf_w,
    output logic [31:0]      rf_data_in,
    output logic [31:0]      busy,
    output logic [CNT_W:0]   fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W:0]   count_q, count_d;
    logic [31:0]      busy_q, busy_d;

    logic        fifo_empty;
    logic        sel_lsu, sel_fifo, sel_byp, grant;
    logic        push, pop, issue_fire;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    function automatic logic hz(input logic [31:0] b, input logic [4:0] r);
        return b[r] && (r != 5'd0);
    endfunction

    always_comb begin
        fifo_empty = (count_q == '0);
        alu_ready  = !reset && (count_q < DEPTH_C);
        sel_lsu    = !reset && lsu_valid;
        sel_fifo   = !reset && !lsu_valid && !fifo_empty;
        sel_byp    = !reset && !lsu_valid && fifo_empty && alu_valid;
        grant      = sel_lsu || sel_fifo || sel_byp;
        w_addr     = '0;
        w_data     = '0;
        if (sel_lsu) begin
            w_addr = lsu_rd;
            w_data = lsu_data;
        end else if (sel_fifo) begin
            w_addr = fifo_rd_q[rd_ptr_q];
            w_data = fifo_data_q[rd_ptr_q];
        end else if (sel_byp) begin
            w_addr = alu_rd;
            w_data = alu_data;
        end
        // x0 writes still consume the grant, they just never reach the RF
        rf_we      = grant && (w_addr != 5'd0);
        rf_w       = w_addr;
        rf_data_in = w_data;
        pop        = sel_fifo;
        push       = alu_valid && alu_ready && !sel_byp;
        issue_stall = issue_valid && (reset
                    || hz(busy_q, issue_rs1)
                    || hz(busy_q, issue_rs2)
                    || hz(busy_q, issue_rd));
        issue_fire = issue_valid && !issue_stall && (issue_rd != 5'd0);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (CNT_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (CNT_W+1)'(1);
        end
        busy_d = busy_q;
        if (rf_we) begin
            busy_d[rf_w] = 1'b0;
        end
        // set after clear so a same-edge collision leaves the bit set
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= alu_rd;
            fifo_data_q[wr_ptr_q] <= alu_data;
        end
    end

    assign busy       = busy_q;
    assign fifo_count = count_q;

    lsu_rd_busy_a: assert property (@(posedge clk) disable iff (reset)
        (lsu_valid && lsu_rd != 5'd0) |-> busy_q[lsu_rd]);

endmodule
